// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its ALU.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 4;
    localparam int OP_W_DEF   = 3;

    // Bit positions inside the 2-bit condition-code result.
    localparam int CARRY = 1;
    localparam int OVF   = 0;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_ADD = 3'd7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: result and {carry, overflow} from two operands and an opcode.
// Zero latency, no flow control.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        ccr
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        ccr    = 2'b00;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result     = {a[DATA_W-2:0], 1'b0};
                ccr[CARRY] = a[DATA_W-1];
                ccr[OVF]   = a[DATA_W-1] ^ a[DATA_W-2];
            end
            OP_SHR: begin
                result     = {1'b0, a[DATA_W-1:1]};
                ccr[CARRY] = a[0];
            end
            OP_SUB: begin
                // Carry reports the borrow out of the unsigned subtraction.
                sum        = {1'b0, a} - {1'b0, b};
                result     = sum[DATA_W-1:0];
                ccr[CARRY] = sum[DATA_W];
                ccr[OVF]   = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                result     = sum[DATA_W-1:0];
                ccr[CARRY] = sum[DATA_W];
                ccr[OVF]   = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; 2 cycles request->response, 1 op per 3 cycles.
// Backpressure: req_ready only in IDLE; the response holds in RESP until the granted rsp_ready bit is high.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*OP_W-1:0] req_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [1:0]        rsp_ccr,
    output logic              busy,
    output logic [7:0]        op_count
);

    state_t            state;
    logic              last_grant;
    logic              gnt;
    logic              gnt_id;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] result_q;
    logic [1:0]        ccr_q;
    logic [DATA_W-1:0] alu_result;
    logic [1:0]        alu_ccr;
    logic [1:0]        rsp_valid_q;
    logic              busy_q;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt       = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            gnt = ~last_grant;
        end else if (!req_valid[0]) begin
            gnt = 1'b1;
        end
        if (reset_n && (state == IDLE) && req_valid[gnt]) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gnt_id      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            ccr_q       <= 2'b00;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            op_count    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        gnt_id <= gnt;
                        a_q    <= gnt ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                        b_q    <= gnt ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                        op_q   <= gnt ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= alu_result;
                    ccr_q       <= alu_ccr;
                    rsp_valid_q <= gnt_id ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_id]) begin
                        last_grant  <= gnt_id;
                        op_count    <= op_count + 8'd1;
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign busy       = busy_q;
    assign rsp_result = (|rsp_valid_q) ? result_q : '0;
    assign rsp_ccr    = (|rsp_valid_q) ? ccr_q : 2'b00;

    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .ccr    (alu_ccr)
    );

endmodule
